// File: rtl/otter_pkg.sv
// Shared types for the fetch front end: redirect source select and fetch FSM states.
package otter_pkg;

  typedef enum logic [2:0] {
    SEL_JAL    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JALR   = 3'd2,
    SEL_MTVEC  = 3'd3,
    SEL_MEPC   = 3'd4
  } pc_sel_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } fetch_state_t;

  localparam logic [1:0] IALIGN_MASK = 2'b11;

  function automatic logic is_trap_sel(input logic [2:0] sel);
    return (sel == SEL_MTVEC) || (sel == SEL_MEPC);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Redirect target select with jalr bit0 clearing and instruction-alignment check.
module pc_next_mux
  import otter_pkg::*;
(
  input  logic [2:0]  i_sel,
  input  logic [31:0] i_jal,
  input  logic [31:0] i_branch,
  input  logic [31:0] i_jalr,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  output logic [31:0] o_target,
  output logic        o_sel_ok,
  output logic        o_misalign
);

  always_comb begin
    o_target = 32'h0000_0000;
    o_sel_ok = 1'b1;
    case (i_sel)
      SEL_JAL:    o_target = i_jal;
      SEL_BRANCH: o_target = i_branch;
      SEL_JALR:   o_target = i_jalr & 32'hFFFF_FFFE;
      SEL_MTVEC:  o_target = i_mtvec;
      SEL_MEPC:   o_target = i_mepc;
      default:    o_sel_ok = 1'b0;
    endcase
  end

  assign o_misalign = o_sel_ok && ((o_target[1:0] & IALIGN_MASK) != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch with decode handshake.
// state | meaning: FETCH request at PC | WAIT response pending | HOLD IR to decode | TRAP parked
module pc_fetch_unit
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] STEP      = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redir_valid,
  input  logic [2:0]  i_redir_sel,
  input  logic [31:0] i_jal,
  input  logic [31:0] i_branch,
  input  logic [31:0] i_jalr,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_ir_valid,
  output logic [31:0] o_ir,
  output logic [31:0] o_ir_pc,
  input  logic        i_ir_ready,
  output logic [31:0] o_pc,
  output logic        o_misalign,
  output logic [31:0] o_misalign_addr
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_req_addr;
  logic [31:0]  r_ir;
  logic [31:0]  r_ir_pc;
  logic [31:0]  r_misalign_addr;
  logic         r_misalign;
  logic         r_kill;
  logic         w_kill_nxt;
  logic         r_to_trap;
  logic         w_to_trap_nxt;
  logic         w_latch_ir;

  logic [31:0]  w_target;
  logic         w_sel_ok;
  logic         w_tgt_misalign;
  logic         w_trapped;
  logic         w_redir;
  logic         w_redir_ok;
  logic         w_redir_bad;

  pc_next_mux u_pc_next_mux (
    .i_sel      (i_redir_sel),
    .i_jal      (i_jal),
    .i_branch   (i_branch),
    .i_jalr     (i_jalr),
    .i_mtvec    (i_mtvec),
    .i_mepc     (i_mepc),
    .o_target   (w_target),
    .o_sel_ok   (w_sel_ok),
    .o_misalign (w_tgt_misalign)
  );

  // Once parked (or draining toward TRAP) only a trap vector or trap return may steer the PC.
  assign w_trapped   = (r_state == TRAP) || r_to_trap;
  assign w_redir     = i_redir_valid && w_sel_ok && (!w_trapped || is_trap_sel(i_redir_sel));
  assign w_redir_ok  = w_redir && !w_tgt_misalign;
  assign w_redir_bad = w_redir && w_tgt_misalign;

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_kill_nxt    = r_kill;
    w_to_trap_nxt = r_to_trap;
    w_latch_ir    = 1'b0;

    if (w_redir_ok) begin
      w_pc_nxt = w_target;
    end

    case (r_state)
      FETCH: begin
        w_state_nxt = WAIT;
        if (w_redir) begin
          w_kill_nxt    = 1'b1;
          w_to_trap_nxt = w_tgt_misalign;
        end
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          w_kill_nxt    = 1'b0;
          w_to_trap_nxt = 1'b0;
          if (w_redir) begin
            w_state_nxt = w_tgt_misalign ? TRAP : FETCH;
          end else if (r_kill) begin
            w_state_nxt = r_to_trap ? TRAP : FETCH;
          end else begin
            w_state_nxt = HOLD;
            w_latch_ir  = 1'b1;
          end
        end else if (w_redir) begin
          w_kill_nxt    = 1'b1;
          w_to_trap_nxt = w_tgt_misalign;
        end
      end
      HOLD: begin
        if (w_redir) begin
          w_state_nxt = w_tgt_misalign ? TRAP : FETCH;
        end else if (i_ir_ready) begin
          w_pc_nxt    = r_pc + STEP;
          w_state_nxt = FETCH;
        end
      end
      TRAP: begin
        if (w_redir_ok) begin
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= FETCH;
      r_pc            <= RESET_VEC;
      r_req_addr      <= RESET_VEC;
      r_kill          <= 1'b0;
      r_to_trap       <= 1'b0;
      r_ir            <= 32'h0000_0000;
      r_ir_pc         <= 32'h0000_0000;
      r_misalign      <= 1'b0;
      r_misalign_addr <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_to_trap  <= w_to_trap_nxt;
      r_misalign <= w_redir_bad;
      if (r_state == FETCH) begin
        r_req_addr <= r_pc;
      end
      if (w_latch_ir) begin
        r_ir    <= i_imem_rdata;
        r_ir_pc <= r_pc;
      end
      if (w_redir_bad) begin
        r_misalign_addr <= w_target;
      end
    end
  end

  // Reset holds the FSM in FETCH, so the request is masked until release.
  assign o_imem_req      = (r_state == FETCH) && i_rst_n;
  assign o_imem_addr     = (r_state == FETCH) ? r_pc : r_req_addr;
  assign o_ir_valid      = (r_state == HOLD);
  assign o_ir            = r_ir;
  assign o_ir_pc         = r_ir_pc;
  assign o_pc            = r_pc;
  assign o_misalign      = r_misalign;
  assign o_misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit against an architectural PC model and a memory model.
module tb_pc_fetch_unit;
  import otter_pkg::*;

  localparam logic [31:0] RVEC = 32'h0000_0100;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_redir_valid = 1'b0;
  logic [2:0]  i_redir_sel = 3'd0;
  logic [31:0] i_jal = '0;
  logic [31:0] i_branch = '0;
  logic [31:0] i_jalr = '0;
  logic [31:0] i_mtvec = '0;
  logic [31:0] i_mepc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_ir_valid;
  logic [31:0] o_ir;
  logic [31:0] o_ir_pc;
  logic        i_ir_ready = 1'b0;
  logic [31:0] o_pc;
  logic        o_misalign;
  logic [31:0] o_misalign_addr;

  always #5 i_clk = ~i_clk;

  pc_fetch_unit #(.RESET_VEC(RVEC), .STEP(32'd4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_redir_valid(i_redir_valid), .i_redir_sel(i_redir_sel),
    .i_jal(i_jal), .i_branch(i_branch), .i_jalr(i_jalr), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_ir_valid(o_ir_valid), .o_ir(o_ir), .o_ir_pc(o_ir_pc), .i_ir_ready(i_ir_ready),
    .o_pc(o_pc), .o_misalign(o_misalign), .o_misalign_addr(o_misalign_addr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // architectural model
  logic [31:0] m_pc;
  logic [31:0] m_mis_addr;
  logic        m_mis;
  logic        m_trap;

  // memory model
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          mem_lat;
  bit          mem_rand_lat;
  bit          mem_spurious;

  int cyc = 0;
  int n_acc = 0;
  bit seen_irv;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 9) < 8) v[1:0] = 2'b00;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RVEC; m_mis = 1'b0; m_mis_addr = 32'h0; m_trap = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
  endtask

  task automatic check_reset_outputs();
    chk1("rst_req", o_imem_req, 1'b0);
    chk1("rst_ir_valid", o_ir_valid, 1'b0);
    chk("rst_ir", o_ir, 32'h0);
    chk("rst_ir_pc", o_ir_pc, 32'h0);
    chk1("rst_misalign", o_misalign, 1'b0);
    chk("rst_misalign_addr", o_misalign_addr, 32'h0);
    chk("rst_pc", o_pc, RVEC);
  endtask

  // One clock cycle: compare DUT against model, advance model, advance memory.
  task automatic tick();
    logic        red;
    logic [31:0] tgt;
    chk("pc", o_pc, m_pc);
    chk1("misalign", o_misalign, m_mis);
    chk("misalign_addr", o_misalign_addr, m_mis_addr);
    chk1("req_while_trapped", o_imem_req && m_trap, 1'b0);
    chk1("req_outstanding", o_imem_req && mem_busy, 1'b0);
    chk1("irv_while_trapped", o_ir_valid && m_trap, 1'b0);
    if (o_imem_req) begin
      chk("req_addr", o_imem_addr, m_pc);
      mem_busy = 1'b1;
      mem_addr = o_imem_addr;
      mem_cnt  = mem_rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
    end else if (mem_busy) begin
      chk("addr_hold", o_imem_addr, mem_addr);
    end
    if (o_ir_valid) begin
      seen_irv = 1'b1;
      chk("ir_pc", o_ir_pc, m_pc);
      chk("ir", o_ir, imem_word(m_pc));
    end

    tgt = 32'h0;
    case (i_redir_sel)
      3'd0: tgt = i_jal;
      3'd1: tgt = i_branch;
      3'd2: tgt = i_jalr & 32'hFFFF_FFFE;
      3'd3: tgt = i_mtvec;
      3'd4: tgt = i_mepc;
      default: tgt = 32'h0;
    endcase
    red = i_redir_valid && (i_redir_sel <= 3'd4) && (!m_trap || i_redir_sel >= 3'd3);
    if (o_ir_valid && i_ir_ready) n_acc++;
    m_mis = 1'b0;
    if (red && tgt[1:0] != 2'b00) begin
      m_mis = 1'b1; m_mis_addr = tgt; m_trap = 1'b1;
    end else if (red) begin
      m_pc = tgt; m_trap = 1'b0;
    end else if (o_ir_valid && i_ir_ready) begin
      m_pc = m_pc + 32'd4;
    end

    @(posedge i_clk);
    #1;
    cyc++;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = imem_word(mem_addr);
        mem_busy      = 1'b0;
      end
    end else if (mem_spurious && $urandom_range(0, 19) == 0) begin
      i_imem_rvalid = 1'b1;
    end
  endtask

  task automatic redirect(input logic [2:0] sel, input logic [31:0] tgt);
    i_redir_sel = sel;
    case (sel)
      3'd0: i_jal = tgt;
      3'd1: i_branch = tgt;
      3'd2: i_jalr = tgt;
      3'd3: i_mtvec = tgt;
      default: i_mepc = tgt;
    endcase
    i_redir_valid = 1'b1;
    tick();
    i_redir_valid = 1'b0;
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!o_imem_req && n < budget) begin
      tick();
      n++;
    end
    chk1("req_timeout", o_imem_req, 1'b1);
  endtask

  task automatic wait_irv(input int budget);
    int n = 0;
    while (!o_ir_valid && n < budget) begin
      tick();
      n++;
    end
    chk1("irv_timeout", o_ir_valid, 1'b1);
  endtask

  initial begin
    int          t0;
    int          nreq;
    logic [31:0] sv_ir;
    logic [31:0] sv_ir_pc;

    model_reset();
    mem_lat = 1; mem_rand_lat = 1'b0; mem_spurious = 1'b0;

    // reset and first fetches with 1-cycle memory
    repeat (2) @(posedge i_clk);
    #1;
    check_reset_outputs();
    i_rst_n = 1'b1;
    i_ir_ready = 1'b1;
    #1;
    chk1("first_req", o_imem_req, 1'b1);
    chk("first_addr", o_imem_addr, RVEC);
    t0 = cyc;
    tick();
    wait_req(20);
    chk("seq_addr1", o_imem_addr, 32'h104);
    chk("req_spacing1", 32'(cyc - t0), 32'd3);
    t0 = cyc;
    tick();
    wait_req(20);
    chk("seq_addr2", o_imem_addr, 32'h108);
    chk("req_spacing2", 32'(cyc - t0), 32'd3);

    // jal redirect while a response is pending
    mem_lat = 3;
    tick();
    seen_irv = 1'b0;
    redirect(SEL_JAL, 32'h200);
    wait_req(20);
    chk("jal_redirect_addr", o_imem_addr, 32'h200);
    chk1("stale_not_presented", seen_irv, 1'b0);
    mem_lat = 1;

    // jalr bit0 clear, misaligned branch parks, mtvec resumes
    tick();
    redirect(SEL_JALR, 32'h301);
    wait_req(20);
    chk("jalr_addr", o_imem_addr, 32'h300);
    chk1("jalr_no_misalign", o_misalign, 1'b0);
    tick();
    redirect(SEL_BRANCH, 32'h302);
    chk1("branch_misalign_pulse", o_misalign, 1'b1);
    chk("branch_misalign_addr", o_misalign_addr, 32'h302);
    nreq = 0;
    for (int i = 0; i < 6; i++) begin
      nreq += int'(o_imem_req);
      tick();
    end
    redirect(SEL_JAL, 32'h500);
    for (int i = 0; i < 3; i++) begin
      nreq += int'(o_imem_req);
      tick();
    end
    chk("trap_no_requests", 32'(nreq), 32'd0);
    redirect(SEL_MTVEC, 32'h80);
    wait_req(20);
    chk("mtvec_addr", o_imem_addr, 32'h80);

    // decode stall then accept with jal redirect
    i_ir_ready = 1'b0;
    tick();
    wait_irv(20);
    sv_ir = o_ir;
    sv_ir_pc = o_ir_pc;
    for (int i = 0; i < 5; i++) begin
      chk("stall_ir", o_ir, sv_ir);
      chk("stall_ir_pc", o_ir_pc, sv_ir_pc);
      chk1("stall_ir_valid", o_ir_valid, 1'b1);
      chk1("stall_no_req", o_imem_req, 1'b0);
      tick();
    end
    i_ir_ready = 1'b1;
    redirect(SEL_JAL, 32'h400);
    wait_req(20);
    chk("ready_redirect_addr", o_imem_addr, 32'h400);

    // PC wrap at top of address space
    tick();
    redirect(SEL_JAL, 32'hFFFF_FFFC);
    wait_req(20);
    chk("wrap_pre_addr", o_imem_addr, 32'hFFFF_FFFC);
    tick();
    wait_irv(20);
    chk("wrap_ir_pc", o_ir_pc, 32'hFFFF_FFFC);
    tick();
    wait_req(20);
    chk("wrap_addr", o_imem_addr, 32'h0);

    // randomized traffic
    mem_rand_lat = 1'b1;
    mem_spurious = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      i_ir_ready    = ($urandom_range(0, 9) < 7);
      i_redir_valid = ($urandom_range(0, 11) == 0) || (m_trap && $urandom_range(0, 3) == 0);
      i_redir_sel   = 3'($urandom_range(0, 7));
      if (m_trap && $urandom_range(0, 1) == 1) i_redir_sel = 3'($urandom_range(3, 4));
      i_jal = rand_tgt(); i_branch = rand_tgt(); i_jalr = rand_tgt();
      i_mtvec = rand_tgt(); i_mepc = rand_tgt();
      tick();
    end
    i_redir_valid = 1'b0;
    i_ir_ready = 1'b1;
    mem_spurious = 1'b0;
    if (m_trap) redirect(SEL_MTVEC, 32'h40);
    chk1("random_progress", n_acc > 100, 1'b1);

    // reset while a response is outstanding
    mem_rand_lat = 1'b0;
    mem_lat = 3;
    wait_req(20);
    tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge i_clk);
    #1;
    i_imem_rvalid = 1'b1;
    i_imem_rdata  = imem_word(mem_addr);
    @(posedge i_clk);
    #1;
    i_imem_rvalid = 1'b0;
    check_reset_outputs();
    model_reset();
    mem_lat = 1;
    i_rst_n = 1'b1;
    #1;
    chk1("post_rst_req", o_imem_req, 1'b1);
    chk("post_rst_addr", o_imem_addr, RVEC);
    tick();
    wait_irv(20);
    chk("post_rst_ir_pc", o_ir_pc, RVEC);
    chk("post_rst_ir", o_ir, imem_word(RVEC));
    tick();
    wait_req(20);
    chk("post_rst_next", o_imem_addr, RVEC + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
